// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer writer: FSM encoding, pixel byte shift, error counter width.
// No logic; latency and backpressure live in the modules that import this.
package fb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LATCH = 3'd2,
        ST_REQ   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    localparam int PIX_SHIFT = 2;
    localparam int ERR_W     = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
endpackage

// File: rtl/fb_raster_addr.sv
// Raster x/y tracker and registered pixel byte address; addr updates one cycle after advance/load.
// No backpressure: the writer pulses advance once per completed pixel. FB_DOUBLE_BUF_EN adds buffer ping-pong.
module fb_raster_addr
    import fb_pkg::*;
#(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          FB_STRIDE = 640,
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter logic [31:0] FB_BASE1  = 32'h0012_C000
) (
    input  logic        PLB_clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic        clear,
    input  logic        load,
    output logic [31:0] addr,
    output logic        last_pixel
`ifdef FB_DOUBLE_BUF_EN
    ,
    output logic        front_buf
`endif
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [31:0] STRIDE = 32'(FB_STRIDE);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   addr_q, addr_d;
    logic          buf_d;

    assign last_pixel = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
    assign addr       = addr_q;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == XW'(H_RES - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(V_RES - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        // Address follows the next position so it is ready when the request goes out.
        if (advance || load || clear) begin
            addr_d = (buf_d ? FB_BASE1 : FB_BASE) + ((32'(y_d) * STRIDE + 32'(x_d)) << PIX_SHIFT);
        end
    end

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

`ifdef FB_DOUBLE_BUF_EN
    logic buf_q, front_q, front_d, frame_wrap;

    assign frame_wrap = advance && !clear && last_pixel;
    assign buf_d      = frame_wrap ? ~buf_q : buf_q;
    assign front_d    = frame_wrap ? buf_q : front_q;
    assign front_buf  = front_q;

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q   <= 1'b0;
            front_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            front_q <= front_d;
        end
    end
`else
    assign buf_d = 1'b0;
`endif
endmodule

// File: rtl/fb_burst_writer.sv
// Pops packed pixel words and issues one single-beat PLB write per pixel; 2 cycles/pixel + 2/word minimum.
// Stalls in REQ until CmdAck and in WAIT until Cmplt; FB_DOUBLE_BUF_EN alternates FB_BASE/FB_BASE1 per frame.
module fb_burst_writer
    import fb_pkg::*;
#(
    parameter int          PIX_W        = 32,
    parameter int          PIX_PER_WORD = 3,
    parameter int          H_RES        = 640,
    parameter int          V_RES        = 480,
    parameter int          FB_STRIDE    = 640,
    parameter logic [31:0] FB_BASE      = 32'h0000_0000,
    parameter logic [31:0] FB_BASE1     = 32'h0012_C000
) (
    input  logic                          PLB_clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [PIX_W*PIX_PER_WORD-1:0] fifo_data,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    output logic                          IP2Bus_MstWr_Req,
    output logic [31:0]                   IP2Bus_Mst_Addr,
    output logic [31:0]                   IP2Bus_MstWr_d,
    input  logic                          Bus2IP_Mst_CmdAck,
    input  logic                          Bus2IP_Mst_Cmplt,
    input  logic                          Bus2IP_Mst_Error,
    output logic                          frame_done,
    output logic                          busy,
    output logic [7:0]                    err_count
`ifdef FB_DOUBLE_BUF_EN
    ,
    output logic                          front_buf
`endif
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

    state_t             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        dat_q, dat_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               cmplt_ok;
    logic               last_pixel;

    // Pixel 0 sits in the MSBs; narrower pixels are zero-extended onto the 32-bit bus.
    function automatic logic [31:0] pick_pix(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] i);
        logic [31:0] p;
        p = '0;
        p[PIX_W-1:0] = w[(PIX_PER_WORD - 1 - int'(i)) * PIX_W +: PIX_W];
        return p;
    endfunction

    assign cmplt_ok = ((state_q == ST_REQ) && Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) ||
                      ((state_q == ST_WAIT) && Bus2IP_Mst_Cmplt);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE:  if (enable && !fifo_empty) state_d = ST_POP;
            ST_POP:   state_d = ST_LATCH;
            ST_LATCH: begin
                word_d  = fifo_data;
                dat_d   = pick_pix(fifo_data, '0);
                idx_d   = '0;
                state_d = ST_REQ;
            end
            ST_REQ:   if (Bus2IP_Mst_CmdAck) state_d = Bus2IP_Mst_Cmplt ? ST_NEXT : ST_WAIT;
            ST_WAIT:  if (Bus2IP_Mst_Cmplt) state_d = ST_NEXT;
            ST_NEXT: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + IDX_W'(1);
                    dat_d   = pick_pix(word_q, idx_q + IDX_W'(1));
                    state_d = ST_REQ;
                end else begin
                    idx_d   = '0;
                    state_d = (enable && !fifo_empty) ? ST_POP : ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        // An errored write still counts as done; only the counter records it.
        if (cmplt_ok && Bus2IP_Mst_Error && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end
        rd_en_d = (state_d == ST_POP);
        req_d   = (state_d == ST_REQ);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_NEXT) && last_pixel;
    end

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rd_en_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dat_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dat_q   <= dat_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    fb_raster_addr #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .FB_STRIDE (FB_STRIDE),
        .FB_BASE   (FB_BASE),
        .FB_BASE1  (FB_BASE1)
    ) u_raster (
        .PLB_clk    (PLB_clk),
        .reset_n    (reset_n),
        .advance    (state_q == ST_NEXT),
        .clear      (1'b0),
        .load       (state_q == ST_LATCH),
        .addr       (IP2Bus_Mst_Addr),
        .last_pixel (last_pixel)
`ifdef FB_DOUBLE_BUF_EN
        ,
        .front_buf  (front_buf)
`endif
    );

    assign fifo_rd_en       = rd_en_q;
    assign IP2Bus_MstWr_Req = req_q;
    assign IP2Bus_MstWr_d   = dat_q;
    assign frame_done       = done_q;
    assign busy             = busy_q;
    assign err_count        = err_q;
endmodule

// File: tb/tb_fb_burst_writer.sv
// Directed bench for fb_burst_writer on a 4x2 raster, stride 8, base 0x1000_0000, 3 x 32-bit pixels per word.
// FIFO and PLB slave are small reactive models; pixel expectations come from the bench's own raster formula.
module tb_fb_burst_writer;
    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'h2000_0000;

    logic        PLB_clk;
    logic        reset_n;
    logic        enable;
    logic [95:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        IP2Bus_MstWr_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [31:0] IP2Bus_MstWr_d;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;
    logic        frame_done;
    logic        busy;
    logic [7:0]  err_count;
`ifdef FB_DOUBLE_BUF_EN
    logic        front_buf;
`endif

    fb_burst_writer #(
        .PIX_W(32), .PIX_PER_WORD(3), .H_RES(4), .V_RES(2), .FB_STRIDE(8),
        .FB_BASE(BASE0), .FB_BASE1(BASE1)
    ) dut (
        .PLB_clk           (PLB_clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .fifo_rd_en        (fifo_rd_en),
        .IP2Bus_MstWr_Req  (IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Addr   (IP2Bus_Mst_Addr),
        .IP2Bus_MstWr_d    (IP2Bus_MstWr_d),
        .Bus2IP_Mst_CmdAck (Bus2IP_Mst_CmdAck),
        .Bus2IP_Mst_Cmplt  (Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error  (Bus2IP_Mst_Error),
        .frame_done        (frame_done),
        .busy              (busy),
        .err_count         (err_count)
`ifdef FB_DOUBLE_BUF_EN
        ,
        .front_buf         (front_buf)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial PLB_clk = 1'b0;
    always #5 PLB_clk = ~PLB_clk;

    // FIFO model: words are pushed by the stimulus, popped on fifo_rd_en, data visible next cycle.
    logic [95:0] mem [0:255];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge PLB_clk) begin
        if (fifo_rd_en) begin
            chk("pop_nonempty", {31'b0, fifo_empty}, 32'd0);
            fifo_data <= mem[pop_cnt];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // PLB slave model: ack same cycle unless held; completion same cycle or dly cycles later.
    logic ack_hold;
    int   dly      = 0;
    int   wcnt     = 0;
    int   err_req  = 0;
    int   err_done = 0;
    assign Bus2IP_Mst_CmdAck = IP2Bus_MstWr_Req && !ack_hold;
    assign Bus2IP_Mst_Cmplt  = (dly == 0) ? Bus2IP_Mst_CmdAck : (wcnt == 1);
    assign Bus2IP_Mst_Error  = Bus2IP_Mst_Cmplt && (err_done < err_req);

    always @(posedge PLB_clk) begin
        if (Bus2IP_Mst_CmdAck && dly != 0) wcnt <= dly;
        else if (wcnt != 0)                wcnt <= wcnt - 1;
        if (Bus2IP_Mst_Cmplt && Bus2IP_Mst_Error) err_done <= err_done + 1;
    end

    // Monitor: log accepted writes, pops and frame_done pulses.
    logic [31:0] wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    int fd_at  = -1;

    always @(negedge PLB_clk) begin
        if (IP2Bus_MstWr_Req && Bus2IP_Mst_CmdAck) begin
            wr_addr[wr_cnt] <= IP2Bus_Mst_Addr;
            wr_data[wr_cnt] <= IP2Bus_MstWr_d;
            wr_cnt          <= wr_cnt + 1;
        end
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_at  <= wr_cnt;
        end
    end

    function automatic logic [31:0] exp_addr(input int n);
        int idx;
        logic [31:0] b;
        idx = n % 8;
        b   = BASE0;
`ifdef FB_DOUBLE_BUF_EN
        if (((n / 8) % 2) == 1) b = BASE1;
`endif
        return b + 32'(((idx / 4) * 8 + (idx % 4)) * 4);
    endfunction

    // mem[0] is the word discarded by the reset test; pixel n comes from mem[n/3 + 1].
    function automatic logic [31:0] exp_data(input int n);
        logic [95:0] w;
        w = mem[n / 3 + 1];
        return w[(2 - (n % 3)) * 32 +: 32];
    endfunction

    task automatic push(input logic [95:0] w);
        mem[push_cnt] = w;
        push_cnt = push_cnt + 1;
    endtask

    task automatic tick;
        @(negedge PLB_clk);
        #1;
    endtask

    task automatic wait_writes(input int target);
        int t;
        t = 0;
        while (wr_cnt < target && t < 4000) begin
            tick();
            t++;
        end
        chk("wr_timeout", {31'b0, wr_cnt >= target}, 32'd1);
    endtask

    task automatic wait_req;
        int t;
        t = 0;
        while (!IP2Bus_MstWr_Req && t < 100) begin
            tick();
            t++;
        end
        chk("req_timeout", {31'b0, IP2Bus_MstWr_Req}, 32'd1);
    endtask

    task automatic wait_idle;
        int t;
        t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_writes(input int from, input int cnt);
        for (int k = from; k < from + cnt; k++) begin
            chk($sformatf("addr%0d", k), wr_addr[k], exp_addr(k));
            chk($sformatf("data%0d", k), wr_data[k], exp_data(k));
        end
    endtask

    int w0, r0;

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        ack_hold = 1'b0;
        repeat (3) tick();
        chk("rst_req",   {31'b0, IP2Bus_MstWr_Req}, 32'd0);
        chk("rst_addr",  IP2Bus_Mst_Addr, 32'd0);
        chk("rst_data",  IP2Bus_MstWr_d, 32'd0);
        chk("rst_rd",    {31'b0, fifo_rd_en}, 32'd0);
        chk("rst_fd",    {31'b0, frame_done}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_err",   {24'b0, err_count}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset in the middle of a held request.
        ack_hold = 1'b1;
        push(96'hDEAD_0000_DEAD_0001_DEAD_0002);
        enable = 1'b1;
        wait_req();
        reset_n = 1'b0;
        #1;
        chk("arst_req",  {31'b0, IP2Bus_MstWr_Req}, 32'd0);
        chk("arst_addr", IP2Bus_Mst_Addr, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        tick();
        ack_hold = 1'b0;
        reset_n  = 1'b1;
        tick();

        // Full frame plus one pixel, CmdAck/Cmplt tied.
        w0 = wr_cnt;
        r0 = rd_cnt;
        push({32'h1111_1111, 32'h2222_2222, 32'h3333_3333});
        push({32'h4444_4444, 32'h5555_5555, 32'h6666_6666});
        push({32'h7777_7777, 32'h8888_8888, 32'h9999_9999});
        wait_writes(w0 + 9);
        wait_idle();
        chk("first_addr", wr_addr[w0], 32'h1000_0000);
        chk("first_data", wr_data[w0], 32'h1111_1111);
        chk("p1_addr",    wr_addr[w0 + 1], 32'h1000_0004);
        chk("p2_data",    wr_data[w0 + 2], 32'h3333_3333);
        chk("p4_line1",   wr_addr[w0 + 4], 32'h1000_0020);
`ifdef FB_DOUBLE_BUF_EN
        chk("p8_wrap",    wr_addr[w0 + 8], BASE1);
        chk("front_f0",   {31'b0, front_buf}, 32'd0);
`else
        chk("p8_wrap",    wr_addr[w0 + 8], 32'h1000_0000);
`endif
        check_writes(w0, 9);
        chk("pops_3",     32'(rd_cnt - r0), 32'd3);
        chk("fd_once",    32'(fd_cnt), 32'd1);
        chk("fd_after8",  32'(fd_at), 32'd8);

        // Completion delayed 5 cycles after CmdAck.
        dly = 5;
        w0  = wr_cnt;
        r0  = rd_cnt;
        push({32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC});
        wait_req();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("wait_req%0d", c),  {31'b0, IP2Bus_MstWr_Req}, 32'd0);
            chk($sformatf("wait_addr%0d", c), IP2Bus_Mst_Addr, exp_addr(w0));
            chk($sformatf("wait_data%0d", c), IP2Bus_MstWr_d, 32'hAAAA_AAAA);
        end
        wait_writes(w0 + 3);
        wait_idle();
        check_writes(w0, 3);
        chk("dly_pops", 32'(rd_cnt - r0), 32'd1);

        // Two errored writes.
        dly     = 0;
        err_req = 2;
        w0      = wr_cnt;
        push({32'hD000_000D, 32'hE000_000E, 32'hF000_000F});
        wait_writes(w0 + 3);
        wait_idle();
        chk("err_two", {24'b0, err_count}, 32'd2);
        check_writes(w0, 3);

        // enable dropped after the first pixel of a word.
        w0 = wr_cnt;
        r0 = rd_cnt;
        push({32'h0101_0101, 32'h0202_0202, 32'h0303_0303});
        push({32'h0404_0404, 32'h0505_0505, 32'h0606_0606});
        wait_writes(w0 + 1);
        enable = 1'b0;
        repeat (20) tick();
        chk("en_rest",  32'(wr_cnt - w0), 32'd3);
        chk("en_pops",  32'(rd_cnt - r0), 32'd1);
        chk("en_idle",  {31'b0, busy}, 32'd0);
        enable = 1'b1;
        wait_writes(w0 + 6);
        wait_idle();
        check_writes(w0, 6);
`ifdef FB_DOUBLE_BUF_EN
        chk("front_f1", {31'b0, front_buf}, 32'd1);
`endif

        // 300 errored writes saturate the counter.
        err_req = 302;
        w0      = wr_cnt;
        for (int j = 0; j < 100; j++) begin
            push({32'hC000_0000 + 32'(j * 3), 32'hC000_0000 + 32'(j * 3 + 1), 32'hC000_0000 + 32'(j * 3 + 2)});
        end
        wait_writes(w0 + 300);
        wait_idle();
        chk("err_sat", {24'b0, err_count}, 32'd255);
        check_writes(w0, 300);

        // Raster continues after the error burst: pixel 321 is (1,0).
        w0 = wr_cnt;
        push({32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0F0F_0F0F});
        wait_writes(w0 + 3);
        wait_idle();
        chk("post_addr", wr_addr[w0], 32'h1000_0004);
        chk("post_err",  {24'b0, err_count}, 32'd255);
        check_writes(w0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
